// File: rtl/pwm_capture.sv
// PWM period / high-time capture with timeout and stuck-level report.
// Optional glitch filter: define PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture #(
  parameter int CNT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pwm_in,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 valid,
  output logic                 timeout,
  output logic                 stuck_level,
  output logic [1:0]           dbg_state
);

  // valid is a bare one-cycle strobe with no ready: the consumer must take
  // period/high_time in the cycle valid is high (they hold afterwards anyway).

  typedef enum logic [1:0] {
    ARM  = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t               state, state_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 s, lvl, lvl_d;
  logic                 rise, fall;
  logic [CNT_WIDTH-1:0] cnt, hi_tmp;
  logic                 cnt_max;
  logic                 load_hi, meas, to_hit;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic s_h1, s_h2, f_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_h1   <= 1'b0;
      s_h2   <= 1'b0;
      f_hold <= 1'b0;
    end else begin
      s_h1   <= s;
      s_h2   <= s_h1;
      f_hold <= lvl;
    end
  end

  // Level follows s only once three consecutive samples agree.
  assign lvl = (s == s_h1 && s_h1 == s_h2) ? s : f_hold;
`else
  assign lvl = s;
`endif

  always_ff @(posedge clk) begin
    if (rst) lvl_d <= 1'b0;
    else     lvl_d <= lvl;
  end

  assign rise    = lvl & ~lvl_d;
  assign fall    = ~lvl & lvl_d;
  assign cnt_max = (cnt == CNT_MAX);

  // Restarting at 1 on the rise makes the count at the next edge the exact tick distance.
  always_ff @(posedge clk) begin
    if (rst)           cnt <= '0;
    else if (rise)     cnt <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    else if (!cnt_max) cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ARM;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_hi    = 1'b0;
    meas       = 1'b0;
    to_hit     = 1'b0;
    case (state)
      ARM: begin
        if (rise) state_next = HIGH;
      end
      HIGH: begin
        if (fall) begin
          load_hi    = 1'b1;
          state_next = LOW;
        end else if (cnt_max) begin
          to_hit     = 1'b1;
          state_next = ARM;
        end
      end
      LOW: begin
        if (rise) begin
          meas       = 1'b1;
          state_next = HIGH;
        end else if (cnt_max) begin
          to_hit     = 1'b1;
          state_next = ARM;
        end
      end
      default: state_next = ARM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period      <= '0;
      high_time   <= '0;
      valid       <= 1'b0;
      timeout     <= 1'b0;
      stuck_level <= 1'b0;
      hi_tmp      <= '0;
    end else begin
      valid <= meas;
      if (load_hi) hi_tmp <= cnt;
      if (meas) begin
        period    <= cnt;
        high_time <= hi_tmp;
        timeout   <= 1'b0;
      end else if (to_hit) begin
        timeout     <= 1'b1;
        stuck_level <= lvl;
        period      <= '0;
        high_time   <= '0;
      end
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: a 16-bit instance for measurement and
// latency, an 8-bit instance so the stuck-line timeouts stay short.
module tb_pwm_capture;

  localparam int W    = 16;
  localparam int W2   = 8;
  localparam int MAX2 = 255;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pwm = 1'b0;
  logic pwm2 = 1'b0;

  logic [W-1:0]  period, high_time;
  logic          valid, timeout, stuck_level;
  logic [1:0]    dbg_state;
  logic [W2-1:0] period2, high_time2;
  logic          valid2, timeout2, stuck_level2;
  logic [1:0]    dbg_state2;

  pwm_capture #(.CNT_WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm),
    .period(period), .high_time(high_time), .valid(valid),
    .timeout(timeout), .stuck_level(stuck_level), .dbg_state(dbg_state)
  );

  pwm_capture #(.CNT_WIDTH(W2), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .rst(rst), .pwm_in(pwm2),
    .period(period2), .high_time(high_time2), .valid(valid2),
    .timeout(timeout2), .stuck_level(stuck_level2), .dbg_state(dbg_state2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0]  exp_q[$];
  logic [2*W2-1:0] exp2_q[$];
  int              vcyc_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push1(input int p, input int h);
    exp_q.push_back({p[W-1:0], h[W-1:0]});
  endtask

  task automatic push2(input int p, input int h);
    exp2_q.push_back({p[W2-1:0], h[W2-1:0]});
  endtask

  // Drive a level just after a rising edge and hold it for t clock ticks.
  task automatic drive(input bit which, input logic v, input int t);
    if (which) pwm2 = v;
    else       pwm  = v;
    repeat (t) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [2*W-1:0] e;
    if (valid) begin
      vcyc_q.push_back(cyc);
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL main_unexpected_valid: observed valid with period %0d, expected no valid", period);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("main_period", 32'(period), 32'(e[2*W-1:W]));
        check("main_high_time", 32'(high_time), 32'(e[W-1:0]));
        check("main_timeout_at_valid", 32'(timeout), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    logic [2*W2-1:0] e;
    if (valid2) begin
      checks++;
      assert (exp2_q.size() > 0) else begin
        errors++;
        $error("FAIL small_unexpected_valid: observed valid with period %0d, expected no valid", period2);
      end
      if (exp2_q.size() > 0) begin
        e = exp2_q.pop_front();
        check("small_period", 32'(period2), 32'(e[2*W2-1:W2]));
        check("small_high_time", 32'(high_time2), 32'(e[W2-1:0]));
        check("small_timeout_at_valid", 32'(timeout2), 32'd0);
      end
    end
  end

  initial begin
    int n;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_period", 32'(period), 32'd0);
    check("rst_high_time", 32'(high_time), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_stuck_level", 32'(stuck_level), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_small_timeout", 32'(timeout2), 32'd0);

    // Steady PWM 20000 / 14000: no valid on the first rise
    drive(0, 1'b0, 10);
    drive(0, 1'b1, 14000);
    drive(0, 1'b0, 6000);
    push1(20000, 14000);
    drive(0, 1'b1, 14000);
    drive(0, 1'b0, 6000);
    push1(20000, 14000);
    drive(0, 1'b1, 30);
    check("steady_valid_count", 32'(vcyc_q.size()), 32'd2);
    if (vcyc_q.size() == 2)
      check("steady_valid_interval", 32'(vcyc_q[1] - vcyc_q[0]), 32'd20000);
    check("steady_timeout", 32'(timeout), 32'd0);

    // Latency from the pwm rise to valid
    drive(0, 1'b0, 70);
    push1(100, 30);
    pwm = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!valid && n < 20);
    check("latency_edges", 32'(n), 32'(LAT));
    @(posedge clk);
    #1;

    // Reset while the FSM sits in HIGH
    drive(0, 1'b1, 10);
    check("state_before_reset", 32'(dbg_state), 32'd1);
    pwm = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_period", 32'(period), 32'd0);
    check("midrst_high_time", 32'(high_time), 32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_timeout", 32'(timeout), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'd0);

    // Period 100 / high 30 after reset: first valid on the second rise
    drive(0, 1'b0, 20);
    drive(0, 1'b1, 30);
    drive(0, 1'b0, 70);
    push1(100, 30);
    drive(0, 1'b1, 30);
    drive(0, 1'b0, 70);
    push1(100, 30);

    // 1-tick low glitch inside a 50-tick high pulse, period 200
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    drive(0, 1'b1, 20);
    drive(0, 1'b0, 1);
    drive(0, 1'b1, 29);
    drive(0, 1'b0, 150);
    push1(200, 50);
`else
    drive(0, 1'b1, 20);
    drive(0, 1'b0, 1);
    push1(21, 20);
    drive(0, 1'b1, 29);
    drive(0, 1'b0, 150);
    push1(179, 29);
`endif
    drive(0, 1'b1, 50);
    drive(0, 1'b0, 20);
    check("main_queue_drained", 32'(exp_q.size()), 32'd0);

    // Stuck low after one full measurement (8-bit instance)
    drive(1, 1'b1, 10);
    drive(1, 1'b0, 20);
    push2(30, 10);
    pwm2 = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      if (n == 10) begin
        #1;
        pwm2 = 1'b0;
      end
      @(negedge clk);
    end while (!timeout2 && n < 400);
    check("stuck_low_ticks", 32'(n), 32'(MAX2 + LAT));
    check("stuck_low_timeout", 32'(timeout2), 32'd1);
    check("stuck_low_level", 32'(stuck_level2), 32'd0);
    check("stuck_low_period", 32'(period2), 32'd0);
    check("stuck_low_high_time", 32'(high_time2), 32'd0);
    @(posedge clk);
    #1;

    // Two rises recover a valid and clear timeout, then the line sticks high
    drive(1, 1'b1, 10);
    drive(1, 1'b0, 20);
    push2(30, 10);
    pwm2 = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == LAT + 2) check("recover_timeout_cleared", 32'(timeout2), 32'd0);
    end while ((n <= LAT + 2 || !timeout2) && n < 400);
    check("stuck_high_ticks", 32'(n), 32'(MAX2 + LAT));
    check("stuck_high_timeout", 32'(timeout2), 32'd1);
    check("stuck_high_level", 32'(stuck_level2), 32'd1);
    check("stuck_high_period", 32'(period2), 32'd0);
    check("stuck_high_high_time", 32'(high_time2), 32'd0);
    check("small_queue_drained", 32'(exp2_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
